// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - shared types and helpers for the DMI bridge
package dmi_pkg;

  localparam int DMI_ADDR_W = 32;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    DMI_OK     = 2'd0,
    DMI_RSVD   = 2'd1,
    DMI_FAILED = 2'd2,
    DMI_BUSY   = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } dmi_state_e;

  typedef struct packed {
    logic                  we;
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] wdata;
  } dmi_req_t;

  function automatic dmi_op_e rsp_op(input logic err);
    return err ? DMI_FAILED : DMI_OK;
  endfunction

endpackage

// File: rtl/dmi_bridge_if.sv
// rtl/dmi_bridge_if.sv - valid/ready request/response bus between bridge and debug module
interface dmi_bridge_if #(
  parameter int ABITS = 7
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [ABITS-1:0] req_addr;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_err;
  logic [31:0]      rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/dmi_timeout_cnt.sv
// rtl/dmi_timeout_cnt.sv - clear/enable counter flagging when an op has waited too long
module dmi_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  // Saturates at LAST so an idle bridge never wraps back into a live count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/dmi_bridge.sv
// rtl/dmi_bridge.sv - DTM-side DMI request bridge onto a single-outstanding debug-module bus
module dmi_bridge
  import dmi_pkg::*;
#(
  parameter int ABITS          = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        jtag_tck_i,
  input  logic        jtag_trstn_i,
  input  logic        dmi_req_i,
  input  logic        dmi_we_i,
  input  logic [31:0] dmi_addr_i,
  input  logic [31:0] dmi_wdata_i,
  output logic        dmi_ack_o,
  output logic [1:0]  dmi_op_o,
  output logic [31:0] dmi_rdata_o,
  output logic        dmi_rdata_valid_o,
  input  logic        dtmcs_dmireset_i,
  input  logic        dtmcs_dmihardreset_i,
  output logic [1:0]  dmistat_o,
  output logic [5:0]  abits_o,
  dmi_bridge_if.master dm
);

  dmi_state_e state_q, state_d;
  dmi_req_t   req_q;
  dmi_op_e    op_q, sticky_q;
  logic       ack_q, rvalid_q;
  logic [31:0] rdata_q;
  logic       req_valid, rsp_ready;
  logic       expired;
  logic       accept, capture, busy_set, rsp_done, tmo, err_set;
  logic       unused_addr;

  // Hard reset swallows everything in its cycle, including a coincident request
  assign accept   = dmi_req_i && !dtmcs_dmihardreset_i;
  assign capture  = accept && (state_q == IDLE) && (sticky_q == DMI_OK);
  assign busy_set = accept && (state_q != IDLE);
  assign rsp_done = (state_q == RSP) && dm.rsp_valid && !dtmcs_dmihardreset_i;
  assign tmo      = (state_q != IDLE) && expired && !((state_q == RSP) && dm.rsp_valid)
                    && !dtmcs_dmihardreset_i;
  assign err_set  = (rsp_done && dm.rsp_err) || tmo;

  always_ff @(posedge jtag_tck_i or negedge jtag_trstn_i) begin
    if (!jtag_trstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (dtmcs_dmihardreset_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (capture) state_d = REQ;
        REQ:     if (expired) state_d = IDLE;
                 else if (dm.req_ready) state_d = RSP;
        RSP:     if (dm.rsp_valid || expired) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Responses are always accepted outside REQ so stale ones drain in IDLE
  always_comb begin
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    case (state_q)
      IDLE:    rsp_ready = 1'b1;
      REQ:     req_valid = 1'b1;
      RSP:     rsp_ready = 1'b1;
      default: rsp_ready = 1'b1;
    endcase
  end

  always_ff @(posedge jtag_tck_i or negedge jtag_trstn_i) begin
    if (!jtag_trstn_i) begin
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      op_q     <= DMI_OK;
      rdata_q  <= '0;
      req_q    <= '0;
      sticky_q <= DMI_OK;
    end else begin
      ack_q    <= accept;
      rvalid_q <= rsp_done || tmo;
      if (rsp_done) begin
        op_q <= rsp_op(dm.rsp_err);
        if (!req_q.we) rdata_q <= dm.rsp_rdata;
      end else if (tmo) begin
        op_q <= DMI_FAILED;
      end
      if (capture) begin
        req_q <= '{we:    dmi_we_i,
                   addr:  {{(DMI_ADDR_W-ABITS){1'b0}}, dmi_addr_i[ABITS-1:0]},
                   wdata: dmi_wdata_i};
      end
      // Sticky keeps its first cause; either reset clear beats a same-cycle set
      if (dtmcs_dmihardreset_i || dtmcs_dmireset_i) begin
        sticky_q <= DMI_OK;
      end else if (sticky_q == DMI_OK) begin
        if (busy_set)     sticky_q <= DMI_BUSY;
        else if (err_set) sticky_q <= DMI_FAILED;
      end
    end
  end

  dmi_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (jtag_tck_i),
    .rst_n  (jtag_trstn_i),
    .clear  (capture || dtmcs_dmihardreset_i),
    .enable (state_q != IDLE),
    .expired(expired)
  );

  assign unused_addr = ^{dmi_addr_i[DMI_ADDR_W-1:ABITS], req_q.addr[DMI_ADDR_W-1:ABITS]};

  assign dm.req_valid      = req_valid;
  assign dm.rsp_ready      = rsp_ready;
  assign dm.req_we         = req_q.we;
  assign dm.req_addr       = req_q.addr[ABITS-1:0];
  assign dm.req_wdata      = req_q.wdata;
  assign dmi_ack_o         = ack_q;
  assign dmi_rdata_valid_o = rvalid_q;
  assign dmi_op_o          = op_q;
  assign dmi_rdata_o       = rdata_q;
  assign dmistat_o         = sticky_q;
  assign abits_o           = 6'(ABITS);

endmodule
